mips_fetch_queue: RTL
=====================

# mips_fetch_queue

Parametrised successor to the single-register MIPS I fetch stage. It decouples code-memory latency from the ID/RF stage through a DEPTH-entry prefetch FIFO holding {opcode, next PC} pairs, with a req/ack handshake toward code memory. It also provides a valid/take handshake toward decode and a single-cycle flush on branch redirect from EX. It sits between the code bus and mips_rf / the execution pipes.

## Interface
- START, 32'h0, reset fetch address (word aligned).
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- PC  out  32  fetch address, registered.
- req  out  1  fetch request; high when count < DEPTH and FV = 0.
- ack  in  1  code memory returns op for PC this cycle; ignored unless req.
- op  in  32  opcode for PC, valid when req & ack.
- RV  out  1  head entry valid (count != 0).
- RO  out  32  head opcode; 32'b0 (NOP) when RV = 0.
- RN  out  32  head next PC (fetch address + 4); 32'b0 when RV = 0.
- take  in  1  decode consumes head this cycle; ignored when RV = 0.
- FV  in  1  branch redirect from EX.
- FA  in  32  redirect target.
- count  out  AW+1  occupancy, 0..DEPTH.

## Operation
- State: PC, rd/wr pointers (AW bits, natural wrap), count (AW+1 bits), storage of DEPTH × 64 bits.
- push = req & ack; pop = RV & take.
- push writes {op, PC+4} at wr, wr += 1, and PC <= PC + 4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
- pop sets rd += 1.
- count <= count + push − pop. Simultaneous push and pop leaves count unchanged. Push when full is impossible because req is low.
- FV = 1 has priority over everything:
  - PC <= FA.
  - rd, wr, count <= 0.
  - An ack in the same cycle is discarded (req is already low).
  - take in the same cycle is ignored.
- FA[1:0] is not checked; the low bits are forwarded as given.
- Storage contents are not reset; only pointers and count are cleared.
- Reset asserted (low), at any time including mid-transfer: PC = START, pointers = 0, count = 0, RV = 0, RO = RN = 0, req = 0 while reset is held. Effect is immediate and asynchronous; release is synchronous to the next posedge.

## Timing
- Without bypass: an op accepted at edge n is visible on RO/RN after edge n (earliest take at cycle n+1). Fetch-to-decode latency is 1 cycle.
- Sustained throughput is 1 op/cycle when ack is held high and take is held high with DEPTH ≥ 2.
- req depends only on registered count and FV, with no combinational path from take.
- Redirect: FV sampled at edge n → PC = FA and RV = 0 after edge n. The first op from FA reaches RO one cycle after its ack.
- Full: count = DEPTH → req = 0. A pop at edge n re-enables req from cycle n+1.

## Configuration
- MIPS_FETCH_BYPASS_EN defined:
  - When count = 0 and push, op and PC+4 drive RO/RN and RV = 1 combinationally in the same cycle.
  - If take is also high, the entry is not written and count stays 0.
  - If take is low, the entry is written normally.
  - FV still forces RV = 0 that cycle.
- Undefined: RO/RN/RV come only from FIFO registers, giving the 1-cycle latency above.

## Test plan
- Reset: hold reset low with START = 32'h00400000 → PC = 32'h00400000, req = 0, RV = 0, RO = 0. Release with ack = 1 and take = 0 → after 4 edges count = 4, req = 0, PC = 32'h00400010.
- Streaming: ack = 1 and take = 1 with op = address-derived pattern → RO sequence matches addresses 0x00400000, 0x00400004, … with no gaps after the first cycle, and count stays at 1 (0 with bypass).
- Redirect with full queue: count = 4, FV = 1, FA = 32'h00000080, ack = 1, take = 1 → next cycle count = 0, RV = 0, PC = 32'h00000080, and no stale op ever reaches RO.
- Wrap: PC = 32'hFFFFFFFC, push → PC = 0 and entry RN = 0. Pointers wrap past DEPTH−1 with FIFO order preserved over 3×DEPTH ops.
- Async reset mid-burst: drop reset between edges with count = 3 → RV and count go to 0 before the next edge.
- Bypass build: count = 0, ack = 1, op = 32'h24020005, take = 1 → RO = 32'h24020005 and RV = 1 in the same cycle, count remains 0. Without the macro, RO = 0 that cycle and RO = 32'h24020005 the next.

Source files
------------

// File: rtl/mips_fetch_queue.sv
// MIPS I prefetch queue: DEPTH-entry FIFO of {op, PC+4}, redirect flush; MIPS_FETCH_BYPASS_EN adds same-cycle forwarding.
// Latency: 1 cycle fetch-to-decode (0 with bypass). Backpressure: req drops when full or on redirect.
// req depends only on registered count, FV and reset, never on take.
module mips_fetch_queue #(
  parameter logic [31:0] START = 32'h0,
  parameter int          DEPTH = 4,
  parameter int          AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [31:0]   PC,
  output logic          req,
  input  logic          ack,
  input  logic [31:0]   op,
  output logic          RV,
  output logic [31:0]   RO,
  output logic [31:0]   RN,
  input  logic          take,
  input  logic          FV,
  input  logic [31:0]   FA,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [63:0]   head;
  logic [31:0]   pc_nxt;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          fifo_vld;

  always_comb begin
    head     = mem[rd];
    pc_nxt   = PC + 32'd4;
    fifo_vld = (count != '0);
    req      = reset & ~FV & (count != FULL);
    push     = req & ack;
    pop      = fifo_vld & take & ~FV;
`ifdef MIPS_FETCH_BYPASS_EN
    // An empty queue forwards the returning op; if decode takes it, it never lands in storage.
    wr_en    = push & ~(~fifo_vld & take);
    RV       = ~FV & (fifo_vld | push);
    if (FV) begin
      RO = '0;
      RN = '0;
    end else if (fifo_vld) begin
      RO = head[63:32];
      RN = head[31:0];
    end else if (push) begin
      RO = op;
      RN = pc_nxt;
    end else begin
      RO = '0;
      RN = '0;
    end
`else
    wr_en    = push;
    RV       = fifo_vld;
    RO       = fifo_vld ? head[63:32] : '0;
    RN       = fifo_vld ? head[31:0]  : '0;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      PC    <= START;
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (FV) begin
      PC    <= FA;
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push)  PC <= pc_nxt;
      if (wr_en) wr <= wr + 1'b1;
      if (pop)   rd <= rd + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  // Storage is deliberately left unreset; pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr] <= {op, pc_nxt};
  end

endmodule
